// File: rtl/dma_engine_if.sv
// Signal bundle for dma_engine: transfer control, bus arbitration and the two memory ports
// (port 0 = PIM buffer, port 1 = PIM). The engine uses the slave view, its controller the master view.
interface dma_engine_if;
    logic        i_start;
    logic        i_dir;
    logic [31:0] i_buf_base;
    logic [31:0] i_pim_base;
    logic [15:0] i_len;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic        o_req_dma;
    logic        i_gnt_dma;

    logic [31:0] o_dma_addr_0;
    logic        o_dma_write_0;
    logic        o_dma_read_0;
    logic [3:0]  o_dma_size_0;
    logic [31:0] o_dma_din_0;
    logic [31:0] i_dma_dout_0;

    logic [31:0] o_dma_addr_1;
    logic        o_dma_write_1;
    logic        o_dma_read_1;
    logic [3:0]  o_dma_size_1;
    logic [31:0] o_dma_din_1;
    logic [31:0] i_dma_dout_1;

    modport slave (
        input  i_start, i_dir, i_buf_base, i_pim_base, i_len, i_gnt_dma,
        input  i_dma_dout_0, i_dma_dout_1,
        output o_busy, o_done, o_err, o_req_dma,
        output o_dma_addr_0, o_dma_write_0, o_dma_read_0, o_dma_size_0, o_dma_din_0,
        output o_dma_addr_1, o_dma_write_1, o_dma_read_1, o_dma_size_1, o_dma_din_1
    );

    modport master (
        output i_start, i_dir, i_buf_base, i_pim_base, i_len, i_gnt_dma,
        output i_dma_dout_0, i_dma_dout_1,
        input  o_busy, o_done, o_err, o_req_dma,
        input  o_dma_addr_0, o_dma_write_0, o_dma_read_0, o_dma_size_0, o_dma_din_0,
        input  o_dma_addr_1, o_dma_write_1, o_dma_read_1, o_dma_size_1, o_dma_din_1
    );
endinterface

// File: rtl/dma_engine.sv
// Word-granular DMA between the PIM buffer (port 0) and the PIM (port 1), one word in flight or held.
// Define DMA_DIR_EN to honour i_dir; otherwise the direction is fixed buffer->PIM.
module dma_engine (
    input  logic        i_clk,
    input  logic        i_rst_n,
    dma_engine_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] buf_base_q, pim_base_q;
    logic [16:0] len_q, rd_cnt_q, wr_cnt_q;
    logic        infl_q, hold_vld_q;
    logic [31:0] hold_q;

    logic        start_bad, start_ok;
    logic        rd_fire, wr_fire, dir_w;
    logic [31:0] src_dout, wr_data, rd_off, wr_off;

    assign start_bad = (bus.i_buf_base[31:28] != 4'h2) || (bus.i_pim_base[31:28] != 4'h4);
    assign start_ok  = (state_q == IDLE) && bus.i_start && !start_bad;

`ifdef DMA_DIR_EN
    logic dir_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dir_q <= 1'b0;
        end else if (start_ok) begin
            dir_q <= bus.i_dir;
        end
    end

    assign dir_w    = dir_q;
    assign src_dout = dir_q ? bus.i_dma_dout_1 : bus.i_dma_dout_0;
`else
    logic unused_dir;

    assign unused_dir = ^{bus.i_dir, bus.i_dma_dout_1};
    assign dir_w      = 1'b0;
    assign src_dout   = bus.i_dma_dout_0;
`endif

    // Every granted cycle retires the pending word, so a read can always issue alongside it.
    assign rd_fire = (state_q == XFER) && bus.i_gnt_dma && (rd_cnt_q < len_q);
    assign wr_fire = (state_q == XFER) && bus.i_gnt_dma && (infl_q || hold_vld_q);
    assign wr_data = hold_vld_q ? hold_q : src_dout;
    assign rd_off  = {13'd0, rd_cnt_q, 2'b00};
    assign wr_off  = {13'd0, wr_cnt_q, 2'b00};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = (bus.i_len == 16'd0) ? DONE : XFER;
                end
            end
            XFER: begin
                if (wr_fire && ((wr_cnt_q + 17'd1) == len_q)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_busy    = (state_q == XFER);
        bus.o_req_dma = (state_q == XFER);
        bus.o_done    = (state_q == DONE);
        bus.o_err     = (state_q == IDLE) && bus.i_start && start_bad;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            buf_base_q <= 32'd0;
            pim_base_q <= 32'd0;
            len_q      <= 17'd0;
            rd_cnt_q   <= 17'd0;
            wr_cnt_q   <= 17'd0;
            infl_q     <= 1'b0;
            hold_vld_q <= 1'b0;
            hold_q     <= 32'd0;
        end else if (start_ok) begin
            buf_base_q <= bus.i_buf_base;
            pim_base_q <= bus.i_pim_base;
            len_q      <= {1'b0, bus.i_len};
            rd_cnt_q   <= 17'd0;
            wr_cnt_q   <= 17'd0;
            infl_q     <= 1'b0;
            hold_vld_q <= 1'b0;
        end else if (state_q == XFER) begin
            if (rd_fire) begin
                rd_cnt_q <= rd_cnt_q + 17'd1;
            end
            if (wr_fire) begin
                wr_cnt_q <= wr_cnt_q + 17'd1;
            end
            infl_q <= rd_fire;
            // Source data is only valid in the cycle after the read; park it if the bus was taken away.
            if (infl_q && !bus.i_gnt_dma) begin
                hold_q     <= src_dout;
                hold_vld_q <= 1'b1;
            end else if (wr_fire) begin
                hold_vld_q <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.o_dma_addr_0  = 32'd0;
        bus.o_dma_write_0 = 1'b0;
        bus.o_dma_read_0  = 1'b0;
        bus.o_dma_size_0  = 4'h0;
        bus.o_dma_din_0   = 32'd0;
        bus.o_dma_addr_1  = 32'd0;
        bus.o_dma_write_1 = 1'b0;
        bus.o_dma_read_1  = 1'b0;
        bus.o_dma_size_1  = 4'h0;
        bus.o_dma_din_1   = 32'd0;
        if (rd_fire) begin
            if (dir_w) begin
                bus.o_dma_read_1 = 1'b1;
                bus.o_dma_addr_1 = pim_base_q + rd_off;
                bus.o_dma_size_1 = 4'hF;
            end else begin
                bus.o_dma_read_0 = 1'b1;
                bus.o_dma_addr_0 = buf_base_q + rd_off;
                bus.o_dma_size_0 = 4'hF;
            end
        end
        if (wr_fire) begin
            if (dir_w) begin
                bus.o_dma_write_0 = 1'b1;
                bus.o_dma_addr_0  = buf_base_q + wr_off;
                bus.o_dma_size_0  = 4'hF;
                bus.o_dma_din_0   = wr_data;
            end else begin
                bus.o_dma_write_1 = 1'b1;
                bus.o_dma_addr_1  = pim_base_q + wr_off;
                bus.o_dma_size_1  = 4'hF;
                bus.o_dma_din_1   = wr_data;
            end
        end
    end
endmodule

// File: tb/tb_dma_engine.sv
// Bench for dma_engine: table vectors, randomized transfers and reset/restart sequences, checked
// against a grant-slot model (word i is read in the i-th granted cycle and written in the next one).
module tb_dma_engine;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dma_engine_if bus();

    dma_engine u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

`ifdef DMA_DIR_EN
    localparam bit DIR_EN = 1'b1;
`else
    localparam bit DIR_EN = 1'b0;
`endif

    typedef struct {
        int          cyc;
        bit          port;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        logic [31:0] bb;
        logic [31:0] pb;
        logic [15:0] len;
        bit          dir;
        logic [31:0] mask;
        bit          poke;
        int          exp_err;
        int          exp_done;
    } vec_t;

    ev_t rd_q[$], wr_q[$], exp_rd_q[$], exp_wr_q[$];
    int  cyc = 0;
    int  done_cnt, done_cyc, err_cnt, busy_cnt, proto_err;
    int  checks = 0;
    int  failures = 0;

    function automatic logic [31:0] mdata(input logic [31:0] a, input bit port);
        return (a * 32'h9E37_79B1) ^ (port ? 32'hC3C3_5A5A : 32'h1234_ABCD);
    endfunction

    function automatic bit gbit(input logic [31:0] mask, input int k);
        return (k < 32) ? mask[k] : 1'b1;
    endfunction

    function automatic int outs_nz();
        return (|{bus.o_busy, bus.o_done, bus.o_err, bus.o_req_dma,
                  bus.o_dma_addr_0, bus.o_dma_write_0, bus.o_dma_read_0, bus.o_dma_size_0, bus.o_dma_din_0,
                  bus.o_dma_addr_1, bus.o_dma_write_1, bus.o_dma_read_1, bus.o_dma_size_1, bus.o_dma_din_1}) ? 1 : 0;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Memory responder: read data appears exactly one cycle after the read, garbage otherwise.
    bit          p0 = 1'b0, p1 = 1'b0;
    logic [31:0] pa0 = 32'd0, pa1 = 32'd0;
    always @(negedge clk) begin
        p0  = bus.o_dma_read_0;
        pa0 = bus.o_dma_addr_0;
        p1  = bus.o_dma_read_1;
        pa1 = bus.o_dma_addr_1;
    end
    always @(posedge clk) begin
        #1;
        bus.i_dma_dout_0 = p0 ? mdata(pa0, 1'b0) : $urandom;
        bus.i_dma_dout_1 = p1 ? mdata(pa1, 1'b1) : $urandom;
    end

    // Monitor: logs bus events and counts protocol violations.
    always @(negedge clk) begin
        if (bus.o_dma_read_0)  rd_q.push_back('{cyc, 1'b0, bus.o_dma_addr_0, 32'h0});
        if (bus.o_dma_read_1)  rd_q.push_back('{cyc, 1'b1, bus.o_dma_addr_1, 32'h0});
        if (bus.o_dma_write_0) wr_q.push_back('{cyc, 1'b0, bus.o_dma_addr_0, bus.o_dma_din_0});
        if (bus.o_dma_write_1) wr_q.push_back('{cyc, 1'b1, bus.o_dma_addr_1, bus.o_dma_din_1});
        if (bus.o_done) begin
            if (done_cnt == 0) done_cyc = cyc;
            done_cnt++;
        end
        if (bus.o_err)  err_cnt++;
        if (bus.o_busy) busy_cnt++;
        if (bus.o_req_dma !== bus.o_busy) proto_err++;
        if ((!bus.i_gnt_dma || !bus.o_busy) &&
            (|{bus.o_dma_addr_0, bus.o_dma_write_0, bus.o_dma_read_0, bus.o_dma_size_0, bus.o_dma_din_0,
               bus.o_dma_addr_1, bus.o_dma_write_1, bus.o_dma_read_1, bus.o_dma_size_1, bus.o_dma_din_1}))
            proto_err++;
        if ((bus.o_dma_read_0 || bus.o_dma_write_0) && bus.o_dma_size_0 != 4'hF) proto_err++;
        if ((bus.o_dma_read_1 || bus.o_dma_write_1) && bus.o_dma_size_1 != 4'hF) proto_err++;
        if (!(bus.o_dma_read_0 || bus.o_dma_write_0) && (|{bus.o_dma_addr_0, bus.o_dma_size_0})) proto_err++;
        if (!(bus.o_dma_read_1 || bus.o_dma_write_1) && (|{bus.o_dma_addr_1, bus.o_dma_size_1})) proto_err++;
        if (!bus.o_dma_write_0 && bus.o_dma_din_0 != 32'd0) proto_err++;
        if (!bus.o_dma_write_1 && bus.o_dma_din_1 != 32'd0) proto_err++;
        if ((bus.o_dma_read_0 && bus.o_dma_write_0) || (bus.o_dma_read_1 && bus.o_dma_write_1)) proto_err++;
        if (bus.o_dma_read_0 && bus.o_dma_read_1) proto_err++;
    end

    task automatic model(input logic [31:0] bb, input logic [31:0] pb, input logic [15:0] len,
                         input bit dir, input logic [31:0] mask,
                         output int e_err, output int e_done, output int e_busy);
        int          g[$];
        int          n;
        logic [31:0] src, dst, off;
        exp_rd_q.delete();
        exp_wr_q.delete();
        e_busy = 0;
        if (bb[31:28] != 4'h2 || pb[31:28] != 4'h4) begin
            e_err  = 1;
            e_done = -1;
            return;
        end
        e_err = 0;
        n     = int'(len);
        if (n == 0) begin
            e_done = 1;
            return;
        end
        src = dir ? pb : bb;
        dst = dir ? bb : pb;
        for (int k = 1; g.size() < n + 1; k++)
            if (gbit(mask, k)) g.push_back(k);
        for (int i = 0; i < n; i++) begin
            off = 32'(i) << 2;
            exp_rd_q.push_back('{g[i], dir, src + off, 32'h0});
            exp_wr_q.push_back('{g[i+1], ~dir, dst + off, mdata(src + off, dir)});
        end
        e_done = g[n] + 1;
        e_busy = g[n];
    endtask

    task automatic cmp_events(input string name);
        int bad;
        bad = -1;
        checks++;
        if (rd_q.size() != exp_rd_q.size()) begin
            failures++;
            $display("FAIL %s reads: got %0d reads expected %0d", name, rd_q.size(), exp_rd_q.size());
        end else begin
            for (int i = 0; i < rd_q.size() && bad < 0; i++)
                if (rd_q[i] != exp_rd_q[i]) bad = i;
            if (bad >= 0) begin
                failures++;
                $display("FAIL %s read %0d: got cyc=%0d port=%0d addr=0x%0h expected cyc=%0d port=%0d addr=0x%0h",
                         name, bad, rd_q[bad].cyc, rd_q[bad].port, rd_q[bad].addr,
                         exp_rd_q[bad].cyc, exp_rd_q[bad].port, exp_rd_q[bad].addr);
            end
        end
        bad = -1;
        checks++;
        if (wr_q.size() != exp_wr_q.size()) begin
            failures++;
            $display("FAIL %s writes: got %0d writes expected %0d", name, wr_q.size(), exp_wr_q.size());
        end else begin
            for (int i = 0; i < wr_q.size() && bad < 0; i++)
                if (wr_q[i] != exp_wr_q[i]) bad = i;
            if (bad >= 0) begin
                failures++;
                $display("FAIL %s write %0d: got cyc=%0d port=%0d addr=0x%0h data=0x%0h expected cyc=%0d port=%0d addr=0x%0h data=0x%0h",
                         name, bad, wr_q[bad].cyc, wr_q[bad].port, wr_q[bad].addr, wr_q[bad].data,
                         exp_wr_q[bad].cyc, exp_wr_q[bad].port, exp_wr_q[bad].addr, exp_wr_q[bad].data);
            end
        end
    endtask

    task automatic clear_logs();
        rd_q.delete();
        wr_q.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        err_cnt   = 0;
        busy_cnt  = 0;
        proto_err = 0;
    endtask

    task automatic run_vec(input vec_t v, input string name, input bit tab);
        int e_err, e_done, e_busy, budget;
        bit dir_e;
        dir_e = DIR_EN ? v.dir : 1'b0;
        model(v.bb, v.pb, v.len, dir_e, v.mask, e_err, e_done, e_busy);
        clear_logs();
        @(posedge clk); #1;
        cyc            = 0;
        bus.i_start    = 1'b1;
        bus.i_dir      = v.dir;
        bus.i_buf_base = v.bb;
        bus.i_pim_base = v.pb;
        bus.i_len      = v.len;
        bus.i_gnt_dma  = v.mask[0];
        budget = ((e_done > 0) ? e_done : 0) + 8;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            cyc = k;
            if (v.poke && k == 2) begin
                bus.i_start    = 1'b1;
                bus.i_dir      = ~v.dir;
                bus.i_buf_base = {4'h2, 28'($urandom)};
                bus.i_pim_base = {4'h4, 28'($urandom)};
                bus.i_len      = 16'($urandom_range(1, 100));
            end else begin
                bus.i_start = 1'b0;
            end
            bus.i_gnt_dma = gbit(v.mask, k);
        end
        bus.i_start   = 1'b0;
        bus.i_gnt_dma = 1'b0;
        check({name, " err_pulses"}, err_cnt, e_err);
        check({name, " done_pulses"}, done_cnt, (e_err != 0) ? 0 : 1);
        check({name, " done_cycle"}, done_cyc, e_done);
        check({name, " busy_cycles"}, busy_cnt, e_busy);
        check({name, " protocol_violations"}, proto_err, 0);
        cmp_events(name);
        if (tab) begin
            check({name, " tab_err"}, err_cnt, v.exp_err);
            check({name, " tab_done"}, done_cyc, v.exp_done);
        end
    endtask

    initial begin
        vec_t        tab[10];
        vec_t        v;
        logic [31:0] src_e, dst_e;
        bit          dir_e;

        tab[0] = '{32'h2000_0000, 32'h4000_0010, 16'd4,      1'b0, 32'hFFFF_FFFF, 1'b0, 0, 6};
        tab[1] = '{32'h2000_0000, 32'h4000_0010, 16'd4,      1'b0, 32'hFFFF_FFF3, 1'b0, 0, 8};
        tab[2] = '{32'h2000_0040, 32'h4000_0080, 16'd0,      1'b0, 32'hFFFF_FFFF, 1'b0, 0, 1};
        tab[3] = '{32'h4000_0000, 32'h4000_0000, 16'd4,      1'b0, 32'hFFFF_FFFF, 1'b0, 1, -1};
        tab[4] = '{32'h2000_0000, 32'h2000_0000, 16'd3,      1'b1, 32'hFFFF_FFFF, 1'b0, 1, -1};
        tab[5] = '{32'h2000_0100, 32'h4000_0200, 16'd2,      1'b1, 32'hFFFF_FFFF, 1'b0, 0, 4};
        tab[6] = '{32'h2123_4560, 32'h4FFF_FFF8, 16'd4,      1'b0, 32'hAAAA_AAAA, 1'b1, 0, 10};
        tab[7] = '{32'h2ABC_0000, 32'h4000_0000, 16'd1,      1'b0, 32'h0000_00F1, 1'b0, 0, 6};
        tab[8] = '{32'h2000_1000, 32'h4000_2000, 16'd5,      1'b1, 32'h5555_5555, 1'b1, 0, 13};
        tab[9] = '{32'h2000_0000, 32'h4100_0000, 16'hFFFF,   1'b0, 32'hFFFF_FFFF, 1'b0, 0, 65537};

        bus.i_start    = 1'b0;
        bus.i_dir      = 1'b0;
        bus.i_buf_base = 32'h2000_0000;
        bus.i_pim_base = 32'h4000_0000;
        bus.i_len      = 16'd4;
        bus.i_gnt_dma  = 1'b1;
        clear_logs();

        // Reset with active-looking inputs: everything must stay quiet.
        #1 rst_n = 1'b0;
        bus.i_start = 1'b1;
        #20;
        check("reset_outputs", outs_nz(), 0);
        @(posedge clk); #1;
        rst_n       = 1'b1;
        bus.i_start = 1'b0;
        @(negedge clk); #1;
        check("idle_after_reset", outs_nz(), 0);
        bus.i_gnt_dma = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_vec(tab[i], $sformatf("vec%0d", i), 1'b1);
            if (i == 0) begin
                check("vec0 rd0_cyc", rd_q[0].cyc, 1);
                check("vec0 rd3_addr", rd_q[3].addr, 32'h2000_000C);
                check("vec0 wr0_cyc", wr_q[0].cyc, 2);
                check("vec0 wr3_addr", wr_q[3].addr, 32'h4000_001C);
                check("vec0 wr3_cyc", wr_q[3].cyc, 5);
            end
            if (i == 1) begin
                check("vec1 held_wr0_cyc", wr_q[0].cyc, 4);
                check("vec1 rd1_cyc", rd_q[1].cyc, 4);
            end
        end

        for (int r = 0; r < 25; r++) begin
            v.bb   = {4'h2, 26'($urandom), 2'b00};
            v.pb   = {4'h4, 26'($urandom), 2'b00};
            if ($urandom_range(0, 9) == 0) v.bb[31:28] = 4'($urandom);
            if ($urandom_range(0, 9) == 0) v.pb[31:28] = 4'($urandom);
            v.len      = 16'($urandom_range(0, 12));
            v.dir      = 1'($urandom);
            v.mask     = $urandom;
            v.poke     = 1'b0;
            v.exp_err  = 0;
            v.exp_done = 0;
            run_vec(v, $sformatf("rnd%0d", r), 1'b0);
        end

        // Reset in the middle of a two-word transfer, right after the first write.
        dir_e = DIR_EN;
        src_e = dir_e ? 32'h4000_0200 : 32'h2000_0100;
        dst_e = dir_e ? 32'h2000_0100 : 32'h4000_0200;
        clear_logs();
        @(posedge clk); #1;
        cyc            = 0;
        bus.i_start    = 1'b1;
        bus.i_dir      = 1'b1;
        bus.i_buf_base = 32'h2000_0100;
        bus.i_pim_base = 32'h4000_0200;
        bus.i_len      = 16'd2;
        bus.i_gnt_dma  = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            cyc         = k;
            bus.i_start = 1'b0;
            #5;
            if (wr_q.size() != 0) break;
        end
        check("rst_first_write_seen", wr_q.size(), 1);
        check("rst_first_write_cyc", wr_q[0].cyc, 2);
        rst_n = 1'b0;
        #1;
        check("rst_outputs_immediate", outs_nz(), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_no_done", done_cnt, 0);
        check("rst_write_count", wr_q.size(), 1);
        check("rst_read_count", rd_q.size(), 2);
        check("rst_write_port", wr_q[0].port, dir_e ? 0 : 1);
        check("rst_write_addr", wr_q[0].addr, dst_e);
        check("rst_write_data", wr_q[0].data, mdata(src_e, dir_e));
        check("rst_idle_outputs", outs_nz(), 0);
        bus.i_gnt_dma = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
